// File: rtl/complex_dot_loader.sv
// complex_dot_loader
//   Streaming operand loader for the complex dot-product stage. Accepts one
//   complex element pair {b2,a2,b1,a1} per beat and packs SIZE beats into
//   one wide operand vector, offered downstream with valid/ready. A vector
//   closed early by elem_last_i is zero-padded so the dot product is exact.
//
//   Build option: define COMPLEX_LOADER_DBUF_EN for two ping-pong banks
//   (one fills while the other waits to drain). Default build has one bank.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   elem_i                   one element pair, lanes [3:0] = {b2,a2,b1,a1}
//   elem_valid_i/ready_o     beat handshake
//   elem_last_i              beat closes the current vector
//   flush_i                  synchronous discard of all buffered state
//   operands_o               packed vector, element k at [4k+3:4k]
//   vec_len_o                real (non-padded) element count, 1..SIZE
//   out_valid_o/out_ready_i  vector handshake
//   busy_o                   some bank is filling or full
module complex_dot_loader #(
  parameter int SIZE   = 16,
  parameter int DATA_W = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [3:0][DATA_W-1:0]           elem_i,
  input  logic                             elem_valid_i,
  output logic                             elem_ready_o,
  input  logic                             elem_last_i,
  input  logic                             flush_i,
  output logic [SIZE*4-1:0][DATA_W-1:0]    operands_o,
  output logic [$clog2(SIZE):0]            vec_len_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             busy_o
);

  localparam int CNT_W = $clog2(SIZE);
  localparam int LEN_W = CNT_W + 1;

`ifdef COMPLEX_LOADER_DBUF_EN
  localparam int   NB       = 2;
  localparam logic PTR_STEP = 1'b1;
`else
  localparam int   NB       = 1;
  localparam logic PTR_STEP = 1'b0;
`endif

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  bank_state_t      bank_q [NB];
  bank_state_t      bank_d [NB];
  logic [LEN_W-1:0] len_q  [NB];
  logic [CNT_W-1:0] fill_cnt_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;

  logic             beat_hs;
  logic             accept;
  logic             close;
  logic             drain;
  logic [LEN_W-1:0] head_len;

  assign beat_hs  = elem_valid_i & elem_ready_o;
  assign accept   = beat_hs & ~flush_i;
  assign close    = accept & (elem_last_i | (fill_cnt_q == CNT_W'(SIZE - 1)));
  assign drain    = out_valid_o & out_ready_i & ~flush_i;

  // Only the write-pointer bank is ever filled; it can be FULL only when
  // every bank is FULL, so ready depends on registered state alone.
  assign elem_ready_o = (bank_q[wr_ptr_q] != BANK_FULL);
  assign out_valid_o  = (bank_q[rd_ptr_q] == BANK_FULL);
  assign head_len     = len_q[rd_ptr_q];
  assign vec_len_o    = out_valid_o ? head_len : '0;

  always_comb begin
    busy_o = 1'b0;
    foreach (bank_q[b]) begin
      if (bank_q[b] != BANK_EMPTY) busy_o = 1'b1;
    end
  end

  // Drain and fill always target different banks (drain needs FULL,
  // fill needs not-FULL), so both updates can apply in the same cycle.
  always_comb begin
    bank_d = bank_q;
    if (drain)  bank_d[rd_ptr_q] = BANK_EMPTY;
    if (accept) bank_d[wr_ptr_q] = close ? BANK_FULL : BANK_FILLING;
    if (flush_i) begin
      foreach (bank_d[b]) bank_d[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      foreach (bank_q[b]) begin
        bank_q[b] <= BANK_EMPTY;
        len_q[b]  <= '0;
      end
      fill_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (flush_i) begin
        fill_cnt_q <= '0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
      end else begin
        if (accept) fill_cnt_q <= close ? '0 : fill_cnt_q + CNT_W'(1);
        if (close) begin
          len_q[wr_ptr_q] <= LEN_W'(fill_cnt_q) + LEN_W'(1);
          wr_ptr_q        <= wr_ptr_q ^ PTR_STEP;
        end
        if (drain) rd_ptr_q <= rd_ptr_q ^ PTR_STEP;
      end
    end
  end

  // Element storage is not reset: slots beyond the head vector's length are
  // masked to zero on the output, so stale contents never become visible.
  for (genvar j = 0; j < 4; j++) begin : g_lane
    logic [DATA_W-1:0] mem_q [NB][SIZE];

    always_ff @(posedge clk_i) begin
      if (beat_hs) mem_q[wr_ptr_q][fill_cnt_q] <= elem_i[j];
    end

    for (genvar k = 0; k < SIZE; k++) begin : g_slot
      localparam logic [LEN_W-1:0] ELEM = LEN_W'(k);
      assign operands_o[4*k+j] = (out_valid_o && (ELEM < head_len))
                                 ? mem_q[rd_ptr_q][k] : '0;
    end
  end

endmodule

// File: tb/tb_complex_dot_loader.sv
// tb_complex_dot_loader
//   Directed self-checking bench for complex_dot_loader (SIZE=16). Inputs
//   are driven and outputs sampled on the falling clock edge; the DUT
//   samples on the rising edge. Expectations adapt to whether
//   COMPLEX_LOADER_DBUF_EN is defined.
module tb_complex_dot_loader;

  localparam int SIZE = 16;

`ifdef COMPLEX_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
  localparam int G    = SIZE;
`else
  localparam bit DBUF = 1'b0;
  localparam int G    = SIZE + 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [3:0][63:0]      elem_i;
  logic                  elem_valid;
  logic                  elem_ready;
  logic                  elem_last;
  logic                  flush;
  logic [SIZE*4-1:0][63:0] operands;
  logic [$clog2(SIZE):0] vec_len;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complex_dot_loader #(.SIZE(SIZE), .DATA_W(64)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .elem_i       (elem_i),
    .elem_valid_i (elem_valid),
    .elem_ready_o (elem_ready),
    .elem_last_i  (elem_last),
    .flush_i      (flush),
    .operands_o   (operands),
    .vec_len_o    (vec_len),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][63:0] mk(input logic [63:0] base, input int k);
    logic [3:0][63:0] r;
    for (int j = 0; j < 4; j++) r[j] = base + 64'(4 * k + j);
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic beat(input logic [3:0][63:0] v, input logic l);
    int n = 0;
    elem_i     = v;
    elem_valid = 1'b1;
    elem_last  = l;
    while (!elem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("beat_timeout", 64'(elem_ready), 64'd1);
    @(negedge clk);
    elem_valid = 1'b0;
    elem_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [63:0] base, input int n, input logic use_last);
    for (int k = 0; k < n; k++) beat(mk(base, k), use_last && (k == n - 1));
  endtask

  task automatic check_vec(input string tag, input logic [63:0] base, input int n);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_len"}, 64'(vec_len), 64'(n));
    for (int i = 0; i < SIZE * 4; i++)
      check($sformatf("%s_op%0d", tag, i), operands[i],
            (i < 4 * n) ? base + 64'(i) : 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SIZE*4-1:0][63:0] snap;
    int  bcnt;
    int  acc;
    bit  prev;
    bit  exp_v;

    rst_n      = 1'b0;
    elem_i     = '0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_len",   64'(vec_len), 64'd0);
    check("rst_ops",   64'(|operands), 64'd0);
    check("rst_ready", 64'(elem_ready), 64'd1);

    // Full vector closed by count, element k = {4k+3,4k+2,4k+1,4k}
    for (int k = 0; k < SIZE - 1; k++) beat(mk(64'd0, k), 1'b0);
    check("full_pre_valid", 64'(out_valid), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    beat(mk(64'd0, SIZE - 1), 1'b0);
    check_vec("full", 64'd0, SIZE);
    @(negedge clk);
    check("full_drained", 64'(out_valid), 64'd0);

    // All-ones vector, then a 5-element short vector
    for (int k = 0; k < SIZE; k++) beat({4{64'hFFFF_FFFF_FFFF_FFFF}}, 1'b0);
    send_vec(64'd100, 5, 1'b1);
    check_vec("short", 64'd100, 5);
    @(negedge clk);

    // Backpressure: A held 20 cycles while the source offers B
    out_ready = 1'b0;
    send_vec(64'd1000, SIZE, 1'b1);
    snap = operands;
    bcnt = 0;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_len", 64'(vec_len), 64'(SIZE));
      check("bp_stable", 64'(operands !== snap), 64'd0);
      if (prev) bcnt++;
      elem_i     = mk(64'd2000, (bcnt < SIZE) ? bcnt : SIZE - 1);
      elem_last  = (bcnt == SIZE - 1);
      elem_valid = 1'b1;
      prev       = elem_ready && (bcnt < SIZE);
      @(negedge clk);
    end
    if (prev) bcnt++;
    check("bp_beats", 64'(bcnt), DBUF ? 64'(SIZE) : 64'd0);
    check("bp_ready", 64'(elem_ready), 64'd0);
    out_ready  = 1'b1;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    @(negedge clk);
    if (DBUF) begin
      check_vec("bp_b", 64'd2000, SIZE);
    end else begin
      check("bp_a_gone", 64'(out_valid), 64'd0);
      send_vec(64'd2000, SIZE, 1'b1);
      check_vec("bp_b", 64'd2000, SIZE);
    end
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);

    // Four vectors streamed continuously
    acc  = 0;
    prev = 1'b0;
    for (int i = 0; i <= 70; i++) begin
      exp_v = (i >= SIZE) && (((i - SIZE) % G) == 0) && (((i - SIZE) / G) < 4);
      check($sformatf("tp_valid%0d", i), 64'(out_valid), 64'(exp_v));
      if (exp_v) check("tp_order", operands[0], 64'(8000 + 100 * ((i - SIZE) / G)));
      if (prev) acc++;
      if (i == 64) check("tp_acc_at64", 64'(acc), DBUF ? 64'd64 : 64'd61);
      elem_i     = mk(64'(8000 + 100 * (acc / SIZE)), acc % SIZE);
      elem_valid = (acc < 4 * SIZE);
      elem_last  = 1'b0;
      prev       = elem_valid && elem_ready;
      @(negedge clk);
    end
    check("tp_acc", 64'(acc), 64'd64);

    // Flush after beat 7, with a discarded closing beat in the flush cycle
    send_vec(64'd3000, 8, 1'b0);
    check("fl_busy_pre", 64'(busy), 64'd1);
    flush      = 1'b1;
    elem_i     = mk(64'd9000, 0);
    elem_valid = 1'b1;
    elem_last  = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(elem_ready), 64'd1);
    send_vec(64'd5000, SIZE, 1'b0);
    check_vec("post_flush", 64'd5000, SIZE);
    @(negedge clk);

    // Asynchronous reset mid-cycle while a vector is held
    out_ready = 1'b0;
    send_vec(64'd6000, SIZE, 1'b1);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy",  64'(busy), 64'd0);
    check("arst_len",   64'(vec_len), 64'd0);
    check("arst_ops",   64'(|operands), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("arst_ready", 64'(elem_ready), 64'd1);
    send_vec(64'd7000, SIZE, 1'b0);
    check_vec("post_rst", 64'd7000, SIZE);
    @(negedge clk);
    check("post_rst_drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/complex_dot_loader.md
# complex_dot_loader

Streaming operand loader directly upstream of the complex matrix-multiply dot-product stage. It accepts one complex element pair per beat, packs SIZE beats into the wide `{b2,a2,b1,a1}` operand vector that stage consumes, and presents the vector with a valid/ready handshake. Vectors that end early on `elem_last_i` are zero-padded, so a short vector yields the correct dot product.

## Interface
- `SIZE`, 16: elements per vector. Must be a power of two, at least 2. Must match the downstream stage.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Asynchronous assert, active-low. Synchronous deassert is provided externally.
- `elem_i`  in  [3:0][63:0]  one element pair `{b2,a2,b1,a1}`, IEEE-754 doubles. `a` is the real part, `b` the imaginary part.
- `elem_valid_i`  in  1  element beat valid.
- `elem_ready_o`  out  1  loader can accept a beat.
- `elem_last_i`  in  1  beat closes the current vector. Qualified by the beat handshake.
- `flush_i`  in  1  synchronous discard of all state.
- `operands_o`  out  [SIZE*4-1:0][63:0]  packed vector. Element k occupies `[4k+3:4k]`.
- `vec_len_o`  out  $clog2(SIZE)+1  number of real (non-padded) elements in `operands_o`, from 1 to SIZE.
- `out_valid_o`  out  1  `operands_o` holds a complete vector.
- `out_ready_i`  in  1  downstream accepts the vector.
- `busy_o`  out  1  any bank is FILLING or FULL.

## Operation
- **Banks.** Each storage bank is SIZE×4×64 bits and carries a state: EMPTY, FILLING or FULL.
- **Beat handshake.** A beat is accepted when `elem_valid_i & elem_ready_o`.
- **Beat placement.**
  - Beat n of the current vector (n counted from 0) is written to slot n of the fill bank.
  - The fill bank moves EMPTY→FILLING on beat 0.
- **Vector close.** The fill bank moves to FULL on an accepted beat that has `elem_last_i=1` or n=SIZE-1, whichever comes first.
  - On close, the fill count resets to 0.
  - `elem_last_i` on beat 0 gives a 1-element vector.
- **Zero padding.** Slots n+1..SIZE-1 of a vector closed early read as `64'h0` (+0.0) on `operands_o`.
  - Padding is never stale data from an earlier vector.
- **Output.**
  - `out_valid_o=1` whenever the oldest bank is FULL.
  - `operands_o` and `vec_len_o` come from that bank.
  - The output handshake (`out_valid_o & out_ready_i`) moves that bank FULL→EMPTY.
- **Ordering.** Vectors leave strictly in arrival order.
- **Stability.** While `out_valid_o & !out_ready_i`, `operands_o` and `vec_len_o` are held bit-stable and `out_valid_o` does not drop, except on flush or reset.
- **Flush.** `flush_i=1` returns every bank to EMPTY and zeroes the fill count.
  - A beat or output handshake in the flush cycle is discarded.
  - Flush overrides everything else in that cycle.
- **Reset mid-operation.** Same effect as flush, applied asynchronously.

## Timing
- **Reset values.**
  - `out_valid_o=0`, `busy_o=0`, `vec_len_o=0`, `operands_o` all zero.
  - `elem_ready_o=1` once reset is released.
- **Latency.** The closing beat is accepted in cycle t. Then `out_valid_o=1` in cycle t+1. No combinational path from `elem_*` to `out_*`.
- **`elem_ready_o`.** A function of registered bank state only. It is not combinational on `out_ready_i`.
- **Sustained throughput.** With `out_ready_i=1` held high and `COMPLEX_LOADER_DBUF_EN` defined: one beat per cycle, no bubbles, one vector every SIZE cycles.
- **Simultaneous close and drain.** A vector can close and another can be drained in the same cycle. Both take effect, and `elem_ready_o` stays 1 if a bank is free after the update.
- **Backpressure.** An unaccepted beat holds nothing. The source keeps `elem_i` stable per standard valid/ready rules; the loader does not check this.
- **Flush timing.** Flush asserted in cycle t gives `out_valid_o=0`, `busy_o=0` and `elem_ready_o=1` in cycle t+1.

## Configuration
- **`COMPLEX_LOADER_DBUF_EN` defined:** two banks, used ping-pong.
  - One bank can fill while the other is FULL awaiting drain.
  - `elem_ready_o=0` only when both banks are FULL.
- **`COMPLEX_LOADER_DBUF_EN` undefined:** one bank.
  - `elem_ready_o=0` while the bank is FULL.
  - After the output handshake in cycle t, `elem_ready_o=1` in cycle t+1, a one-cycle bubble per vector.
  - Sustained rate is one vector per SIZE+1 cycles.

## Test plan
- **Full vector.** Reset, then SIZE=16 beats with element k = {4k+3,4k+2,4k+1,4k} (as 64-bit integers), `out_ready_i=1` → one cycle after beat 15, `out_valid_o=1`, `operands_o[i]=i` for i=0..63, `vec_len_o=16`.
- **Short vector.** 5 beats with `elem_last_i` on beat 4, sent after a full vector of all-ones data → `vec_len_o=5`, slots 5..15 read exactly `64'h0`, slots 0..4 match stimulus.
- **Backpressure.** `out_ready_i=0` for 20 cycles after the first vector closes, source always valid.
  - Output stays bit-stable throughout.
  - With DBUF: a second full vector is accepted, then `elem_ready_o=0`.
  - Without DBUF: `elem_ready_o=0` immediately after close.
  - On release, vectors drain in order.
- **Back-to-back (DBUF).** 4 vectors continuous, `out_ready_i=1` → 64 consecutive accepted beats, `out_valid_o` pulses at cycles 16, 32, 48 and 64 after the first beat.
- **Flush and reset mid-vector.**
  - `flush_i` pulsed after beat 7 → `busy_o=0` and `out_valid_o=0` next cycle; the next 16 beats form a clean vector with `vec_len_o=16`.
  - Repeat with `rst_ni` asserted asynchronously mid-cycle → outputs take reset values immediately.
